// File: rtl/instdec_seq.sv
// instdec_seq: sequenced instruction decoder for the Simple RISC Machine.
// It accepts a 16-bit instruction, drives the register-file read indices
// itself, and then holds a registered decoded bundle until the consumer
// takes it.
//
// Ports
//   clk, reset_n         clock, async active-low reset
//   in_valid/in_inst     instruction offer; in_ready = decoder can accept
//   rd_en_a/rd_num_a     register-file read request, port A
//   rd_en_b/rd_num_b     read request, port B (only when READ_PORTS = 2)
//   out_valid/out_ready  decoded bundle handshake
//   opcode, op, shift    raw ir fields
//   sximm5, sximm8       sign-extended immediates, DATA_W bits wide
//   writenum, wr_en      destination register and its write enable
//   halt, illegal        HALT decoded / unsupported encoding
//   halted               stopped by an issued HALT until reset
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for an instruction, in_ready = 1
// READ1   | first read (both reads when two ports are available)
// READ2   | second read on port A (single-port only)
// ISSUE   | bundle valid; may accept the next instruction when taken
// HALTED  | HALT taken; stays here until reset
module instdec_seq #(
   parameter int DATA_W     = 16,
   parameter int READ_PORTS = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   input  logic [15:0]       in_inst,
   output logic              in_ready,
   output logic              rd_en_a,
   output logic [2:0]        rd_num_a,
   output logic              rd_en_b,
   output logic [2:0]        rd_num_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2:0]        opcode,
   output logic [1:0]        op,
   output logic [1:0]        shift,
   output logic [DATA_W-1:0] sximm5,
   output logic [DATA_W-1:0] sximm8,
   output logic [2:0]        writenum,
   output logic              wr_en,
   output logic              halt,
   output logic              illegal,
   output logic              halted
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_READ1  = 3'd1,
      S_READ2  = 3'd2,
      S_ISSUE  = 3'd3,
      S_HALTED = 3'd4
   } state_t;

   // Read plan of one instruction: how many reads, their indices, and flags.
   typedef struct packed {
      logic [1:0] nrd;
      logic [2:0] i1;
      logic [2:0] i2;
      logic       wr;
      logic       hlt;
      logic       ill;
   } plan_t;

   function automatic plan_t plan_of(input logic [15:0] w);
      plan_t p;
      p = '0;
      case (w[15:11])
         5'b110_10: p.wr = 1'b1;
         5'b110_00: begin p.nrd = 2'd1; p.i1 = w[2:0]; p.wr = 1'b1; end
         5'b101_00,
         5'b101_10: begin p.nrd = 2'd2; p.i1 = w[10:8]; p.i2 = w[2:0]; p.wr = 1'b1; end
         5'b101_01: begin p.nrd = 2'd2; p.i1 = w[10:8]; p.i2 = w[2:0]; end
         5'b101_11: begin p.nrd = 2'd1; p.i1 = w[2:0]; p.wr = 1'b1; end
         5'b011_00: begin p.nrd = 2'd1; p.i1 = w[10:8]; p.wr = 1'b1; end
         5'b100_00: begin p.nrd = 2'd2; p.i1 = w[10:8]; p.i2 = w[7:5]; end
         5'b111_00: p.hlt = 1'b1;
         default:   p.ill = 1'b1;
      endcase
      return p;
   endfunction

   state_t      state;
   logic [15:0] ir;
   logic        wr_q;
   logic        hlt_q;
   logic        ill_q;
   logic        two_left;
   logic [2:0]  idx2_q;
   plan_t       in_plan;
   logic        accept;

   assign in_plan = plan_of(in_inst);

   // A taken HALT never accepts a follower, so ISSUE withholds in_ready for it.
   assign in_ready = reset_n &
                     ((state == S_IDLE) |
                      ((state == S_ISSUE) & out_ready & ~hlt_q));
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         ir        <= '0;
         wr_q      <= 1'b0;
         hlt_q     <= 1'b0;
         ill_q     <= 1'b0;
         two_left  <= 1'b0;
         idx2_q    <= '0;
         rd_en_a   <= 1'b0;
         rd_num_a  <= '0;
         rd_en_b   <= 1'b0;
         rd_num_b  <= '0;
         out_valid <= 1'b0;
         halted    <= 1'b0;
      end else begin
         rd_en_a  <= 1'b0;
         rd_num_a <= '0;
         rd_en_b  <= 1'b0;
         rd_num_b <= '0;
         if (accept) begin
            ir       <= in_inst;
            wr_q     <= in_plan.wr;
            hlt_q    <= in_plan.hlt;
            ill_q    <= in_plan.ill;
            two_left <= (READ_PORTS == 1) && (in_plan.nrd == 2'd2);
            idx2_q   <= in_plan.i2;
            if (in_plan.nrd == 2'd0) begin
               state     <= S_ISSUE;
               out_valid <= 1'b1;
            end else begin
               state     <= S_READ1;
               out_valid <= 1'b0;
               rd_en_a   <= 1'b1;
               rd_num_a  <= in_plan.i1;
               if ((READ_PORTS == 2) && (in_plan.nrd == 2'd2)) begin
                  rd_en_b  <= 1'b1;
                  rd_num_b <= in_plan.i2;
               end
            end
         end else begin
            case (state)
               S_READ1: begin
                  if (two_left) begin
                     state    <= S_READ2;
                     rd_en_a  <= 1'b1;
                     rd_num_a <= idx2_q;
                  end else begin
                     state     <= S_ISSUE;
                     out_valid <= 1'b1;
                  end
               end
               S_READ2: begin
                  state     <= S_ISSUE;
                  out_valid <= 1'b1;
               end
               S_ISSUE: begin
                  if (out_ready) begin
                     out_valid <= 1'b0;
                     if (hlt_q) begin
                        state  <= S_HALTED;
                        halted <= 1'b1;
                     end else begin
                        state <= S_IDLE;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign opcode   = ir[15:13];
   assign op       = ir[12:11];
   assign shift    = ir[4:3];
   assign sximm5   = {{(DATA_W-5){ir[4]}}, ir[4:0]};
   assign sximm8   = {{(DATA_W-8){ir[7]}}, ir[7:0]};
   // MOV immediate is the only encoding whose target sits in the Rn field.
   assign writenum = ill_q ? 3'd0 : ((ir[15:11] == 5'b110_10) ? ir[10:8] : ir[7:5]);
   assign wr_en    = wr_q;
   assign halt     = hlt_q;
   assign illegal  = ill_q;

endmodule

// File: tb/tb_instdec_seq.sv
module tb_instdec_seq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid, out_ready, in_ready;
   logic [15:0] in_inst;
   logic        rd_en_a, rd_en_b, out_valid, wr_en, halt, illegal, halted;
   logic [2:0]  rd_num_a, rd_num_b, opcode, writenum;
   logic [1:0]  op, shift;
   logic [15:0] sximm5, sximm8;

   logic        v2, r2_ready, o2_ready, a2e, b2e, ov2, wr2, h2, il2, hd2;
   logic [15:0] i2_inst, sx5_2, sx8_2;
   logic [2:0]  a2n, b2n, opc2, wn2;
   logic [1:0]  op2, sh2;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [2:0]  opc;
      logic [1:0]  op;
      logic [1:0]  sh;
      logic [15:0] sx5;
      logic [15:0] sx8;
      logic [2:0]  wn;
      logic        wn_chk;
      logic        wr;
      logic        hlt;
      logic        ill;
   } exp_t;

   exp_t       bq[$];
   logic [2:0] rdq[$];

   always #5 clk = ~clk;

   instdec_seq #(.DATA_W(16), .READ_PORTS(1)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_inst(in_inst), .in_ready(in_ready),
      .rd_en_a(rd_en_a), .rd_num_a(rd_num_a), .rd_en_b(rd_en_b), .rd_num_b(rd_num_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .opcode(opcode), .op(op), .shift(shift), .sximm5(sximm5), .sximm8(sximm8),
      .writenum(writenum), .wr_en(wr_en), .halt(halt), .illegal(illegal), .halted(halted)
   );

   instdec_seq #(.DATA_W(16), .READ_PORTS(2)) dut2 (
      .clk(clk), .reset_n(reset_n),
      .in_valid(v2), .in_inst(i2_inst), .in_ready(r2_ready),
      .rd_en_a(a2e), .rd_num_a(a2n), .rd_en_b(b2e), .rd_num_b(b2n),
      .out_valid(ov2), .out_ready(o2_ready),
      .opcode(opc2), .op(op2), .shift(sh2), .sximm5(sx5_2), .sximm8(sx8_2),
      .writenum(wn2), .wr_en(wr2), .halt(h2), .illegal(il2), .halted(hd2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected reads and bundle for one instruction on the single-port decoder.
   task automatic push(input logic [15:0] w);
      exp_t e;
      e.opc = w[15:13]; e.op = w[12:11]; e.sh = w[4:3];
      e.sx5 = {{11{w[4]}}, w[4:0]};
      e.sx8 = {{8{w[7]}}, w[7:0]};
      e.wn = w[7:5]; e.wn_chk = 1'b0; e.wr = 1'b0; e.hlt = 1'b0; e.ill = 1'b0;
      case (w[15:11])
         5'b11010: begin e.wn = w[10:8]; e.wr = 1'b1; e.wn_chk = 1'b1; end
         5'b11000: begin rdq.push_back(w[2:0]); e.wr = 1'b1; e.wn_chk = 1'b1; end
         5'b10100, 5'b10110: begin
            rdq.push_back(w[10:8]); rdq.push_back(w[2:0]); e.wr = 1'b1; e.wn_chk = 1'b1;
         end
         5'b10101: begin rdq.push_back(w[10:8]); rdq.push_back(w[2:0]); end
         5'b10111: begin rdq.push_back(w[2:0]); e.wr = 1'b1; e.wn_chk = 1'b1; end
         5'b01100: begin rdq.push_back(w[10:8]); e.wr = 1'b1; e.wn_chk = 1'b1; end
         5'b10000: begin rdq.push_back(w[10:8]); rdq.push_back(w[7:5]); end
         5'b11100: e.hlt = 1'b1;
         default:  begin e.ill = 1'b1; e.wn = 3'd0; e.wn_chk = 1'b1; end
      endcase
      bq.push_back(e);
   endtask

   task automatic sample();
      exp_t e;
      if (rd_en_a) begin
         if (rdq.size() == 0) chk("spurious_rd_a", rd_en_a, 0);
         else chk("sb_rd_num_a", rd_num_a, rdq.pop_front());
      end else begin
         chk("rd_num_a_idle", rd_num_a, 0);
      end
      chk("rd_en_b_1port", rd_en_b, 0);
      if (out_valid) begin
         if (bq.size() == 0) chk("spurious_valid", out_valid, 0);
         else begin
            e = bq[0];
            chk("sb_opcode", opcode, e.opc);
            chk("sb_op", op, e.op);
            chk("sb_shift", shift, e.sh);
            chk("sb_sximm5", sximm5, e.sx5);
            chk("sb_sximm8", sximm8, e.sx8);
            chk("sb_wr_en", wr_en, e.wr);
            chk("sb_halt", halt, e.hlt);
            chk("sb_illegal", illegal, e.ill);
            if (e.wn_chk) chk("sb_writenum", writenum, e.wn);
         end
      end
   endtask

   // The bundle is consumed at the edge if valid and ready were both high before it.
   task automatic step();
      logic hs;
      hs = out_valid && out_ready;
      @(posedge clk);
      #1;
      if (hs && bq.size() != 0) void'(bq.pop_front());
      sample();
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; in_inst = '0; out_ready = 1'b1;
      v2 = 1'b0; i2_inst = '0; o2_ready = 1'b1;
      #12;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_rd_en_a", rd_en_a, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_writenum", writenum, 0);
      chk("rst_halted", halted, 0);
      chk("rst_in_ready2", r2_ready, 0);
      @(negedge clk); reset_n = 1'b1;
      step();
      chk("idle_in_ready", in_ready, 1);

      // ADD R2,R1,R0 on both decoders
      in_valid = 1'b1; in_inst = 16'hA140; push(16'hA140);
      v2 = 1'b1; i2_inst = 16'hA140;
      step();
      in_valid = 1'b0; in_inst = 16'h1234; v2 = 1'b0; i2_inst = 16'h5678;
      chk("add_t1_en_a", rd_en_a, 1);
      chk("add_t1_num_a", rd_num_a, 1);
      chk("add_t1_valid", out_valid, 0);
      chk("add2_t1_en_a", a2e, 1);
      chk("add2_t1_num_a", a2n, 1);
      chk("add2_t1_en_b", b2e, 1);
      chk("add2_t1_num_b", b2n, 0);
      chk("add2_t1_valid", ov2, 0);
      step();
      chk("add_t2_en_a", rd_en_a, 1);
      chk("add_t2_num_a", rd_num_a, 0);
      chk("add2_t2_valid", ov2, 1);
      chk("add2_t2_writenum", wn2, 2);
      chk("add2_t2_en_a", a2e, 0);
      step();
      chk("add_t3_valid", out_valid, 1);
      chk("add_t3_writenum", writenum, 2);
      chk("add_t3_wr_en", wr_en, 1);
      chk("add_t3_op", op, 0);
      chk("add2_t3_valid", ov2, 0);
      step();
      chk("add_t4_valid", out_valid, 0);

      // MOV R3,#-1
      in_valid = 1'b1; in_inst = 16'hD3FF; push(16'hD3FF);
      step();
      in_valid = 1'b0;
      chk("mov_valid", out_valid, 1);
      chk("mov_rd_en", rd_en_a, 0);
      chk("mov_sximm8", sximm8, 16'hFFFF);
      chk("mov_writenum", writenum, 3);
      step();
      chk("mov_done", out_valid, 0);

      // STR R5,[R4] stalled 3 cycles, then CMP R6,R7 and MVN R1,R2 back-to-back
      out_ready = 1'b0;
      in_valid = 1'b1; in_inst = 16'h84A0; push(16'h84A0);
      step();
      in_valid = 1'b0;
      chk("str_rd1", rd_num_a, 4);
      step();
      chk("str_rd2", rd_num_a, 5);
      step();
      chk("str_valid", out_valid, 1);
      chk("str_in_ready", in_ready, 0);
      in_valid = 1'b1; in_inst = 16'hAE07; push(16'hAE07);
      repeat (3) begin
         step();
         chk("stall_valid", out_valid, 1);
         chk("stall_in_ready", in_ready, 0);
         chk("stall_rd_en", rd_en_a, 0);
      end
      out_ready = 1'b1;
      step();
      chk("cmp_rd1_en", rd_en_a, 1);
      chk("cmp_rd1_num", rd_num_a, 6);
      in_inst = 16'hB822; push(16'hB822);
      step();
      chk("cmp_rd2_num", rd_num_a, 7);
      step();
      chk("cmp_valid", out_valid, 1);
      chk("cmp_wr_en", wr_en, 0);
      chk("cmp_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("mvn_rd_en", rd_en_a, 1);
      chk("mvn_rd_num", rd_num_a, 2);
      step();
      chk("mvn_valid", out_valid, 1);
      chk("mvn_writenum", writenum, 1);
      step();
      chk("mvn_done", out_valid, 0);

      // opcode 001: illegal
      in_valid = 1'b1; in_inst = 16'h2000; push(16'h2000);
      step();
      in_valid = 1'b0;
      chk("ill_valid", out_valid, 1);
      chk("ill_flag", illegal, 1);
      chk("ill_rd_en", rd_en_a, 0);
      chk("ill_writenum", writenum, 0);
      chk("ill_wr_en", wr_en, 0);
      step();

      // HALT, then more offers
      in_valid = 1'b1; in_inst = 16'hE000; push(16'hE000);
      step();
      chk("halt_valid", out_valid, 1);
      chk("halt_flag", halt, 1);
      chk("halt_in_ready", in_ready, 0);
      in_inst = 16'hA140;
      step();
      chk("halted_flag", halted, 1);
      chk("halted_valid", out_valid, 0);
      repeat (3) begin
         step();
         chk("halted_hold", halted, 1);
         chk("halted_in_ready", in_ready, 0);
         chk("halted_rd_en", rd_en_a, 0);
      end
      in_valid = 1'b0;

      // reset out of HALTED, then reset again in the middle of READ1
      reset_n = 1'b0;
      #1;
      chk("rst2_halted", halted, 0);
      @(negedge clk); reset_n = 1'b1;
      step();
      chk("rst2_in_ready", in_ready, 1);
      in_valid = 1'b1; in_inst = 16'hA140; push(16'hA140);
      step();
      in_valid = 1'b0;
      chk("mid_rd_en", rd_en_a, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_rd_en", rd_en_a, 0);
      chk("mid_rst_rd_num", rd_num_a, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_opcode", opcode, 0);
      chk("mid_rst_wr_en", wr_en, 0);
      rdq.delete();
      bq.delete();
      @(negedge clk); reset_n = 1'b1;
      repeat (5) begin
         step();
         chk("post_rst_valid", out_valid, 0);
         chk("post_rst_rd_en", rd_en_a, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instdec_seq.md
# instdec_seq

Sequenced, parametrised instruction decoder for the Simple RISC Machine datapath. It accepts 16-bit instructions over a valid/ready handshake and latches each one into an internal instruction register. It then drives the register-file read index sequence itself, one operand per cycle or two per cycle, with no external `nsel`. Finally it presents a registered decoded bundle to the controller/datapath over a second valid/ready handshake. It sits between instruction fetch and the datapath, and supports back-to-back issue and a sticky HALT.

## Interface
Parameters:
- `DATA_W`, 16: width of sign-extended immediates; legal range is 8 and above.
- `READ_PORTS`, 1: register-file read ports driven; legal values are 1 and 2.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: instruction offered.
- `in_inst` in 16: instruction word.
- `in_ready` out 1: decoder can accept.
- `rd_en_a` out 1: read request, port A.
- `rd_num_a` out 3: register index, port A.
- `rd_en_b` out 1: read request, port B; tied 0 when `READ_PORTS`=1.
- `rd_num_b` out 3: register index, port B.
- `out_valid` out 1: decoded bundle valid.
- `out_ready` in 1: consumer accepts the bundle.
- `opcode` out 3: `ir[15:13]`.
- `op` out 2: `ir[12:11]`, also the ALUop.
- `shift` out 2: `ir[4:3]`.
- `sximm5` out DATA_W: `ir[4:0]` sign-extended.
- `sximm8` out DATA_W: `ir[7:0]` sign-extended.
- `writenum` out 3: destination register.
- `wr_en` out 1: instruction writes a register.
- `halt` out 1: HALT decoded.
- `illegal` out 1: unsupported encoding.
- `halted` out 1: decoder stopped by an issued HALT.

## Operation
- Fields: Rn=`ir[10:8]`, Rd=`ir[7:5]`, Rm=`ir[2:0]`. All bundle outputs are decoded from `ir` and are stable while `out_valid`=1.
- Read plan by `{opcode,op}`, giving reads in order, then the write target:
  - 110/10 MOV imm: no reads; write Rn.
  - 110/00 MOV shift: read Rm; write Rd.
  - 101/00 ADD and 101/10 AND: read Rn then Rm; write Rd.
  - 101/01 CMP: read Rn then Rm; `wr_en`=0.
  - 101/11 MVN: read Rm; write Rd.
  - 011/00 LDR: read Rn; write Rd.
  - 100/00 STR: read Rn then Rd; `wr_en`=0.
  - 111/00 HALT: no reads; `halt`=1; `wr_en`=0.
  - Any other encoding: no reads; `illegal`=1; `wr_en`=0; `writenum`=0.
- States:
  - IDLE: `in_ready`=1. An accepted instruction loads `ir`; next state is READ1, or ISSUE if the plan has no reads.
  - READ1: `rd_en_a`=1 with the first index. With `READ_PORTS`=2 and two reads in the plan, `rd_en_b`=1 with the second index in the same cycle. Next state is READ2 if one read remains, else ISSUE.
  - READ2: `rd_en_a`=1 with the second index; next state is ISSUE.
  - ISSUE: `out_valid`=1. On `out_ready`:
    - HALT goes to HALTED.
    - Otherwise, if `in_valid` is high, the next instruction is accepted in the same cycle (`in_ready`=`out_ready` in ISSUE) and the FSM proceeds as from IDLE.
    - Otherwise it goes to IDLE.
  - HALTED: `halted`=1, `in_ready`=0, `out_valid`=0. Exits only on reset.
- `rd_en_*`=0 and `rd_num_*`=0 in every state where that port is not requesting.

## Timing
- Reset (`reset_n` low, asynchronous): state=IDLE, `ir`=0, and every output is 0, including `in_ready`, which is forced 0 while `reset_n` is low. `in_ready` rises in the first cycle after deassertion. Reset mid-sequence abandons the instruction with no further read or issue.
- Latency for an instruction accepted at edge T:
  - First read cycle is T+1.
  - `out_valid` rises at T+1+k, where k is the number of read cycles: 0, 1 or 2 with one port; 0 or 1 with two ports.
- Back-to-back: the handshake at ISSUE plus a simultaneous accept gives no bubble cycle between `out_valid` and the next read.
- Stall: with `out_ready`=0 the bundle holds unchanged indefinitely; `in_ready`=0 and no reads are issued.
- `in_inst` is sampled only on an `in_valid`&&`in_ready` edge; changes at other times have no effect.
- Sign extension: bits `[DATA_W-1:5]` / `[DATA_W-1:8]` replicate `ir[4]` / `ir[7]`.

## Test plan
- Reset, then ADD R2,R1,R0 (0xA140), `READ_PORTS`=1, `out_ready`=1 → `rd_num_a`=1 at T+1; `rd_num_a`=0 at T+2; `out_valid` at T+3 with `writenum`=2, `wr_en`=1, `op`=00.
- Same ADD with `READ_PORTS`=2 → at T+1 `rd_en_a`=`rd_en_b`=1 with `rd_num_a`=1, `rd_num_b`=0; `out_valid` at T+2.
- MOV R3,#-1 (0xD3FF) → no `rd_en`; `out_valid` at T+1; `sximm8`=0xFFFF (DATA_W=16); `writenum`=3.
- STR, CMP and MVN issued back-to-back with `out_ready` held 0 for 3 cycles on STR → STR reads Rn then Rd, and its bundle is held stable while stalled. CMP follows with no bubble after release, with `wr_en`=0. MVN reads only Rm.
- HALT (0xE000), then further `in_valid` → `halt`=1 issued, then `halted`=1 and `in_ready`=0 until reset.
- Opcode 001 word → `illegal`=1 with no reads. Separately, assert `reset_n` low during READ1 → all outputs 0 immediately; no `out_valid` afterward.
